// File: rtl/writeback_queue_stage.sv
// rtl/writeback_queue_stage.sv - DEPTH-entry in-order writeback queue with register commit on dequeue
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNTER_EN.
module writeback_queue_stage #(
    parameter int ADDR_WIDTH         = 32,
    parameter int DATA_WIDTH         = 32,
    parameter int NUM_REGISTERS      = 32,
    parameter int DEPTH              = 4,
    parameter int RETIRE_COUNT_WIDTH = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               prev_done,
    output logic                               stall_prev,
    input  logic                               next_stall,
    output logic                               done_next,
    input  logic [ADDR_WIDTH-1:0]              program_count_in,
    input  logic                               program_count_valid_in,
    input  logic [$clog2(NUM_REGISTERS)-1:0]   write_register_in,
    input  logic                               write_register_valid_in,
    input  logic [DATA_WIDTH-1:0]              result_data_in,
    input  logic                               result_data_valid_in,
    input  logic                               exception_in,
    output logic [$clog2(NUM_REGISTERS)-1:0]   write_register,
    output logic [DATA_WIDTH-1:0]              write_data,
    output logic                               write_activate,
    output logic [ADDR_WIDTH-1:0]              program_count_out,
    output logic                               program_count_valid_out,
    output logic                               exception_out,
    output logic [NUM_REGISTERS-1:0]           pending_write_mask,
    output logic [$clog2(DEPTH):0]             occupancy,
    output logic [RETIRE_COUNT_WIDTH-1:0]      retired_count
);

    localparam int REG_IDX = $clog2(NUM_REGISTERS);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;

    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]      count_q, count_d;

    logic [ADDR_WIDTH-1:0] pc_q    [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_d    [DEPTH];
    logic                  pcv_q   [DEPTH];
    logic                  pcv_d   [DEPTH];
    logic [REG_IDX-1:0]    wreg_q  [DEPTH];
    logic [REG_IDX-1:0]    wreg_d  [DEPTH];
    logic                  wregv_q [DEPTH];
    logic                  wregv_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_d  [DEPTH];
    logic                  datav_q [DEPTH];
    logic                  datav_d [DEPTH];
    logic                  exc_q   [DEPTH];
    logic                  exc_d   [DEPTH];

    logic transfer_prev;
    logic transfer_next;
    logic full;

    // An entry commits a register only if it names a real destination with valid data.
    function automatic logic entry_writes(input logic wv, input logic dv, input logic exc,
                                          input logic [REG_IDX-1:0] r);
        return wv && dv && !exc && (r != '0);
    endfunction

    always_comb begin
        full          = (count_q == OCC_W'(DEPTH));
        done_next     = rst && !flush && (count_q != '0);
        transfer_next = done_next && !next_stall;
        stall_prev    = !rst || flush || (full && !transfer_next);
        transfer_prev = prev_done && !stall_prev;
    end

    always_comb begin
        write_register          = wreg_q[rd_ptr_q];
        write_data              = data_q[rd_ptr_q];
        program_count_out       = pc_q[rd_ptr_q];
        program_count_valid_out = pcv_q[rd_ptr_q];
        exception_out           = exc_q[rd_ptr_q];
        write_activate          = transfer_next &&
                                  entry_writes(wregv_q[rd_ptr_q], datav_q[rd_ptr_q],
                                               exc_q[rd_ptr_q], wreg_q[rd_ptr_q]);
        occupancy               = count_q;
    end

    // Walk live entries from the head so stale slots never contribute.
    always_comb begin
        logic [PTR_W-1:0] slot;
        pending_write_mask = '0;
        slot               = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr_q + PTR_W'(k);
            if (rst && (OCC_W'(k) < count_q) &&
                entry_writes(wregv_q[slot], datav_q[slot], exc_q[slot], wreg_q[slot])) begin
                pending_write_mask[wreg_q[slot]] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (transfer_prev) wr_ptr_d = wr_ptr_q + 1'b1;
            if (transfer_next) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({transfer_prev, transfer_next})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        pc_d    = pc_q;
        pcv_d   = pcv_q;
        wreg_d  = wreg_q;
        wregv_d = wregv_q;
        data_d  = data_q;
        datav_d = datav_q;
        exc_d   = exc_q;
        if (transfer_prev) begin
            pc_d[wr_ptr_q]    = program_count_in;
            pcv_d[wr_ptr_q]   = program_count_valid_in;
            wreg_d[wr_ptr_q]  = write_register_in;
            wregv_d[wr_ptr_q] = write_register_valid_in;
            data_d[wr_ptr_q]  = result_data_in;
            datav_d[wr_ptr_q] = result_data_valid_in;
            exc_d[wr_ptr_q]   = exception_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        pcv_q   <= pcv_d;
        wreg_q  <= wreg_d;
        wregv_q <= wregv_d;
        data_q  <= data_d;
        datav_q <= datav_d;
        exc_q   <= exc_d;
    end

`ifdef WB_RETIRE_COUNTER_EN
    logic [RETIRE_COUNT_WIDTH-1:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (transfer_next) retired_d = retired_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) retired_q <= '0;
        else      retired_q <= retired_d;
    end

    assign retired_count = retired_q;
`else
    assign retired_count = '0;
`endif

endmodule

// File: doc/writeback_queue_stage.md
# writeback_queue_stage

Parametrised successor to the single-entry writeback stage. It is a DEPTH-entry writeback queue at the tail of the pipeline, sitting between the memory stage and the retire/commit stage. Each entry commits its register-file write only when it transfers downstream, which keeps writes in program order and suppresses them for x0 or excepting entries. It also exports a pending-destination mask for hazard detection and an optional retired-instruction counter.

## Interface
Parameters:
- ADDR_WIDTH, 32, program counter width
- DATA_WIDTH, 32, result/write data width
- NUM_REGISTERS, 32, architectural register count; index width is $clog2(NUM_REGISTERS)
- DEPTH, 4, queue entries; power of two, at least 2
- RETIRE_COUNT_WIDTH, 64, width of retired_count

Ports:
- clk, in, 1, sole clock; all state updates on its rising edge
- rst, in, 1, synchronous, active-low reset (rst==0 resets on the clk edge)
- flush, in, 1, discard all queued entries
- prev_done, in, 1, upstream offers an entry
- stall_prev, out, 1, queue refuses the upstream entry this cycle
- next_stall, in, 1, downstream refuses the head entry
- done_next, out, 1, head entry is offered downstream
- program_count_in, in, ADDR_WIDTH, entry PC
- program_count_valid_in, in, 1, PC valid
- write_register_in, in, REG_IDX, destination register
- write_register_valid_in, in, 1, entry writes a register
- result_data_in, in, DATA_WIDTH, write-back value
- result_data_valid_in, in, 1, value valid
- exception_in, in, 1, entry carries an exception
- write_register, out, REG_IDX, register-file write index
- write_data, out, DATA_WIDTH, register-file write value
- write_activate, out, 1, register-file write strobe
- program_count_out, out, ADDR_WIDTH, head PC
- program_count_valid_out, out, 1, head PC valid
- exception_out, out, 1, head exception flag
- pending_write_mask, out, NUM_REGISTERS, bit r is set if any queued entry will write r
- occupancy, out, $clog2(DEPTH)+1, number of queued entries
- retired_count, out, RETIRE_COUNT_WIDTH, count of entries transferred downstream

## Operation
- Circular FIFO with read pointer, write pointer and occupancy count. Pointers wrap modulo DEPTH.
- Handshake signals:
  - transfer_prev = prev_done && !stall_prev.
  - transfer_next = done_next && !next_stall.
- done_next = rst && !flush && occupancy != 0.
- stall_prev = !rst || flush || (occupancy == DEPTH && !transfer_next). When full, a dequeue in the same cycle frees the slot.
- Simultaneous enqueue and dequeue leave occupancy unchanged. Both pointers advance.
- write_activate = transfer_next && head.write_register_valid && head.result_data_valid && !head.exception && head.write_register != 0.
- write_register and write_data always present the head fields. They are meaningful only when write_activate is high.
- head outputs (program_count_out, program_count_valid_out, exception_out) hold the head entry and are undefined when occupancy is 0.
- pending_write_mask is the OR over valid entries of the one-hot destination. The same qualification as write_activate applies, minus the transfer term. Bit 0 is always 0.
- flush has priority over everything: all entries are discarded at the edge, and no write or retire occurs that cycle.
- Exception entries still transfer downstream. They never write a register.

## Timing
- Reset (rst==0 at an edge): occupancy=0, pointers=0, retired_count=0. While rst==0: done_next=0, stall_prev=1, write_activate=0, pending_write_mask=0.
- Latency from accept to head: one cycle. An entry accepted at edge N is offered (done_next=1) in cycle N+1 when the queue was empty.
- The register write is combinational with transfer_next. The register file samples it at the same edge as the dequeue.
- pending_write_mask and occupancy are combinational from registered state. They reflect state after the last edge.
- Reset asserted mid-operation discards all entries. No write is issued in any cycle with rst==0.
- Empty queue with prev_done: accept; done_next stays 0 that cycle (no bypass).

## Configuration
- WB_RETIRE_COUNTER_EN defined: retired_count increments by 1 on every transfer_next. It wraps at 2^RETIRE_COUNT_WIDTH and clears on reset only (not on flush).
- WB_RETIRE_COUNTER_EN undefined: no counter register. retired_count is tied to 0.

## Test plan
- Reset then single entry: reg 5, data 0xDEADBEEF, valid, next_stall=0 -> done_next in cycle 1; write_activate with write_register=5, write_data=0xDEADBEEF; retired_count=1 (macro on).
- Fill with next_stall=1, DEPTH=4, regs 1..4 -> occupancy=4, stall_prev=1, pending_write_mask=0x1E. Release -> writes in order 1,2,3,4, one per cycle.
- Full queue, prev_done=1 and next_stall=0 in the same cycle -> stall_prev=0, occupancy stays 4, pointers wrap correctly over 12 entries.
- Entries to x0 and with exception_in=1 -> transfer with write_activate=0; their bits are absent from pending_write_mask; exception_out=1 at head.
- Three entries queued, flush=1 for one cycle -> occupancy=0, mask=0, no write_activate, retired_count unchanged.
- rst=0 mid-stream with two entries -> next cycle occupancy=0, done_next=0, stall_prev=1, retired_count=0.
